// File: rtl/seq_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_checker_pkg
// Description : Shared state type and encoding width for the sequence checker.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_checker_pkg;

  localparam int c_STATE_W = 2;

  typedef enum logic [c_STATE_W-1:0] {
    HUNT = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } seq_state_t;

endpackage : seq_checker_pkg
`default_nettype wire

// File: rtl/seq_checker_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : seq_checker_sat_cnt
// Description : W-bit up counter that sticks at all-ones; async active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_checker_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule : seq_checker_sat_cnt
`default_nettype wire

// File: rtl/seq_checker.sv
`default_nettype none
// ============================================================================
// Module      : seq_checker
// Description : Locks onto a +1 counter stream, flags and counts bad steps.
//               Error counter present only when SEQ_CHECKER_ERRCNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_checker
  import seq_checker_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LOCK_N = 4,
  parameter int MISS_N = 2,
  parameter int ECNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vld,
  input  logic [WIDTH-1:0]  value,
  output logic              locked,
  output logic              err,
  output logic [WIDTH-1:0]  exp_value,
  output logic [ECNT_W-1:0] err_cnt
);

  localparam int c_GOOD_W = $clog2(LOCK_N + 1);
  localparam int c_MISS_W = $clog2(MISS_N + 1);
  localparam logic [c_GOOD_W-1:0] c_GOOD_LAST = c_GOOD_W'(LOCK_N - 1);
  localparam logic [c_MISS_W-1:0] c_MISS_LAST = c_MISS_W'(MISS_N - 1);

  seq_state_t           r_state;
  logic                 r_locked;
  logic                 r_err;
  logic [WIDTH-1:0]     r_exp;
  logic [c_GOOD_W-1:0]  r_good;
  logic [c_MISS_W-1:0]  r_miss;
  logic                 w_match;
  logic [WIDTH-1:0]     w_reseed;

  assign w_match  = (value == r_exp);
  assign w_reseed = value + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= HUNT;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
      r_exp    <= '0;
      r_good   <= '0;
      r_miss   <= '0;
    end else begin
      r_err <= 1'b0;
      if (vld) begin
        case (r_state)
          HUNT: begin
            r_exp   <= w_reseed;
            r_good  <= '0;
            r_state <= ACQ;
          end
          ACQ: begin
            r_exp <= w_reseed;
            if (!w_match) begin
              r_good <= '0;
            end else if (r_good == c_GOOD_LAST) begin
              r_good   <= '0;
              r_miss   <= '0;
              r_locked <= 1'b1;
              r_state  <= LOCK;
            end else begin
              r_good <= r_good + 1'b1;
            end
          end
          LOCK: begin
            if (w_match) begin
              r_miss <= '0;
              r_exp  <= w_reseed;
            end else begin
              // Free-run on a miss so a single corrupted sample costs one error.
              r_err <= 1'b1;
              r_exp <= r_exp + 1'b1;
              if (r_miss == c_MISS_LAST) begin
                r_miss   <= '0;
                r_locked <= 1'b0;
                r_state  <= HUNT;
              end else begin
                r_miss <= r_miss + 1'b1;
              end
            end
          end
          default: begin
            r_locked <= 1'b0;
            r_state  <= HUNT;
          end
        endcase
      end
    end
  end

  assign locked    = r_locked;
  assign err       = r_err;
  assign exp_value = r_exp;

`ifdef SEQ_CHECKER_ERRCNT_EN
  logic w_err_inc;

  // Counts on the same edge that raises err.
  assign w_err_inc = vld && (r_state == LOCK) && !w_match;

  seq_checker_sat_cnt #(
    .W (ECNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_err_inc),
    .o_cnt (err_cnt)
  );
`else
  assign err_cnt = '0;
`endif

endmodule : seq_checker
`default_nettype wire

// File: tb/tb_seq_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_checker
// Description : Directed self-checking bench for seq_checker (ECNT_W = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_checker;

`ifdef SEQ_CHECKER_ERRCNT_EN
  localparam bit c_ERRCNT_EN = 1'b1;
`else
  localparam bit c_ERRCNT_EN = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       vld   = 1'b0;
  logic [7:0] value = 8'd0;
  logic       locked;
  logic       err;
  logic [7:0] exp_value;
  logic [3:0] err_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int m_cnt = 0;

  seq_checker #(
    .WIDTH  (8),
    .LOCK_N (4),
    .MISS_N (2),
    .ECNT_W (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vld       (vld),
    .value     (value),
    .locked    (locked),
    .err       (err),
    .exp_value (exp_value),
    .err_cnt   (err_cnt)
  );

  always #10 clk = ~clk;

  function automatic logic [3:0] want_cnt();
    return c_ERRCNT_EN ? 4'(m_cnt) : 4'd0;
  endfunction

  task automatic drive(input logic v, input logic [7:0] val);
    @(negedge clk);
    vld   = v;
    value = val;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    vld   = 1'b0;
    value = 8'd0;
    m_cnt = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++;
    if ({locked, err, exp_value, err_cnt} !== 14'd0) begin
      n_bad++;
      $display("FAIL reset: got L=%b E=%b X=%0d C=%0d, want all 0", locked, err, exp_value, err_cnt);
    end
  endtask

  task automatic test_acquire(input string tag);
    logic [7:0] vals [5] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
    logic       lk   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] xv;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, vals[i]);
      xv = vals[i] + 8'd1;
      n_cmp++;
      if ({locked, err, exp_value, err_cnt} !== {lk[i], 1'b0, xv, want_cnt()}) begin
        n_bad++;
        $display("FAIL %s[%0d]: got L=%b E=%b X=%0d C=%0d, want L=%b E=0 X=%0d C=%0d",
                 tag, i, locked, err, exp_value, err_cnt, lk[i], xv, want_cnt());
      end
    end
  endtask

  task automatic test_glitch();
    logic [7:0] vals [4] = '{8'd5, 8'd99, 8'd7, 8'd8};
    logic       ee   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] xv   [4] = '{8'd6, 8'd7, 8'd8, 8'd9};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, vals[i]);
      if (ee[i]) m_cnt++;
      n_cmp++;
      if ({locked, err, exp_value, err_cnt} !== {1'b1, ee[i], xv[i], want_cnt()}) begin
        n_bad++;
        $display("FAIL glitch[%0d]: got L=%b E=%b X=%0d C=%0d, want L=1 E=%b X=%0d C=%0d",
                 i, locked, err, exp_value, err_cnt, ee[i], xv[i], want_cnt());
      end
    end
  endtask

  task automatic test_jump();
    logic [7:0] vals [9] = '{8'd9, 8'd10, 8'd50, 8'd51, 8'd52, 8'd53, 8'd54, 8'd55, 8'd56};
    logic       lk   [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       ee   [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0] xv   [9] = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd53, 8'd54, 8'd55, 8'd56, 8'd57};
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, vals[i]);
      if (ee[i]) m_cnt++;
      n_cmp++;
      if ({locked, err, exp_value, err_cnt} !== {lk[i], ee[i], xv[i], want_cnt()}) begin
        n_bad++;
        $display("FAIL jump[%0d]: got L=%b E=%b X=%0d C=%0d, want L=%b E=%b X=%0d C=%0d",
                 i, locked, err, exp_value, err_cnt, lk[i], ee[i], xv[i], want_cnt());
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] vals [10] = '{8'd248, 8'd249, 8'd250, 8'd251, 8'd252,
                              8'd253, 8'd254, 8'd255, 8'd0, 8'd1};
    logic       lk   [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [7:0] xv;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vals[i]);
      xv = vals[i] + 8'd1;
      n_cmp++;
      if ({locked, err, exp_value, err_cnt} !== {lk[i], 1'b0, xv, 4'd0}) begin
        n_bad++;
        $display("FAIL wrap[%0d]: got L=%b E=%b X=%0d C=%0d, want L=%b E=0 X=%0d C=0",
                 i, locked, err, exp_value, err_cnt, lk[i], xv);
      end
    end
  endtask

  task automatic test_saturation();
    logic [7:0] xv = 8'd2;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, xv + 8'd100);
      xv = xv + 8'd1;
      if (m_cnt < 15) m_cnt++;
      n_cmp++;
      if ({locked, err, exp_value, err_cnt} !== {1'b1, 1'b1, xv, want_cnt()}) begin
        n_bad++;
        $display("FAIL sat_bad[%0d]: got L=%b E=%b X=%0d C=%0d, want L=1 E=1 X=%0d C=%0d",
                 i, locked, err, exp_value, err_cnt, xv, want_cnt());
      end
      drive(1'b0, 8'hAA);
      n_cmp++;
      if ({locked, err, exp_value, err_cnt} !== {1'b1, 1'b0, xv, want_cnt()}) begin
        n_bad++;
        $display("FAIL sat_gap[%0d]: got L=%b E=%b X=%0d C=%0d, want L=1 E=0 X=%0d C=%0d",
                 i, locked, err, exp_value, err_cnt, xv, want_cnt());
      end
      drive(1'b1, xv);
      xv = xv + 8'd1;
      n_cmp++;
      if ({locked, err, exp_value, err_cnt} !== {1'b1, 1'b0, xv, want_cnt()}) begin
        n_bad++;
        $display("FAIL sat_good[%0d]: got L=%b E=%b X=%0d C=%0d, want L=1 E=0 X=%0d C=%0d",
                 i, locked, err, exp_value, err_cnt, xv, want_cnt());
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 8'd200);
    #4;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({locked, err, exp_value, err_cnt} !== 14'd0) begin
      n_bad++;
      $display("FAIL async_reset: got L=%b E=%b X=%0d C=%0d, want all 0",
               locked, err, exp_value, err_cnt);
    end
    do_reset();
    test_acquire("relock");
  endtask

  initial begin
    test_reset();
    test_acquire("acquire");
    test_glitch();
    test_jump();
    test_wrap();
    test_saturation();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_seq_checker
`default_nettype wire
